lc3b_mem_responder: RTL and testbench

Memory-side responder for the LC-3b core's single-port memory interface. Accepts one read or write request at a time from the datapath/control pair (mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write), models a fixed access latency, and completes each transaction with a one-cycle mem_resp pulse. Sits opposite the CPU as the bench/FPGA memory. Holds a byte-writable word array.

---
 rtl/lc3b_types.sv | 21 ++
 rtl/lc3b_byte_ram.sv | 27 ++
 rtl/lc3b_mem_responder.sv | 136 +++++++++++++
 tb/tb_lc3b_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: the 16-bit machine word and the memory responder states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Memory responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc3b_mem_state;

  // Wide enough for the largest wait-cycle count (15)
  localparam int LC3B_MEM_CNT_W = 4;

  // Word index width for a power-of-two word count (at least one bit)
  function automatic int lc3b_idx_w(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/lc3b_byte_ram.sv
// Byte-lane writable word array: synchronous write per lane, combinational read.
// No reset on the storage, so contents survive a reset of the responder.
module lc3b_byte_ram
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = lc3b_idx_w(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [1:0]       i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  lc3b_word         i_wdata,
  output lc3b_word         o_rdata
);

  logic [7:0] r_lo [DEPTH_WORDS];
  logic [7:0] r_hi [DEPTH_WORDS];

  // Update only the byte lanes that are enabled
  always_ff @(posedge clk) begin
    if (i_we[0]) r_lo[i_idx] <= i_wdata[7:0];
    if (i_we[1]) r_hi[i_idx] <= i_wdata[15:8];
  end

  assign o_rdata = {r_hi[i_idx], r_lo[i_idx]};

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory interface: one request at a time,
// fixed LATENCY wait cycles, one-cycle mem_resp, byte-writable word array.
// Optional macro LC3B_MEM_RANGE_CHECK_EN adds mem_err for addresses beyond the
// array; without it, upper address bits are ignored and addresses wrap.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; captures the request when seen
// WAIT  | counting down the access latency; request inputs ignored
// RESP  | mem_resp high for one cycle; write lanes commit at the closing edge
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [1:0] mem_byte_enable,
  input  lc3b_word   mem_address,
  input  lc3b_word   mem_wdata,
  output lc3b_word   mem_rdata,
  output logic       mem_resp
`ifdef LC3B_MEM_RANGE_CHECK_EN
  ,
  output logic       mem_err
`endif
);

  localparam int IDX_W = lc3b_idx_w(DEPTH_WORDS);

  lc3b_mem_state             r_state;
  lc3b_mem_state             w_state_nxt;
  logic [LC3B_MEM_CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]          r_idx;
  lc3b_word                  r_wdata;
  logic [1:0]                r_be;
  logic                      r_is_write;
  logic                      r_oor;
  lc3b_word                  r_rdata;

  logic                      w_req;
  logic                      w_req_write;
  logic                      w_req_oor;
  logic [IDX_W-1:0]          w_req_idx;
  logic [IDX_W-1:0]          w_ram_idx;
  logic                      w_op_write;
  logic                      w_op_oor;
  logic [1:0]                w_ram_we;
  lc3b_word                  w_ram_rdata;
  logic                      w_unused_addr;

  assign w_req       = mem_read | mem_write;
  // A simultaneous read and write is serviced as a read
  assign w_req_write = mem_write & ~mem_read;
  assign w_req_idx   = mem_address[IDX_W:1];
  // Bit 0 and (without range check) the bits above the index do not address the array
  assign w_unused_addr = ^mem_address;

`ifdef LC3B_MEM_RANGE_CHECK_EN
  assign w_req_oor = (mem_address >> (IDX_W + 1)) != '0;
  assign mem_err   = (r_state == RESP) && r_oor;
`else
  assign w_req_oor = 1'b0;
`endif

  // In IDLE the live request drives the array so LATENCY=0 can read on the capture edge
  assign w_ram_idx  = (r_state == IDLE) ? w_req_idx   : r_idx;
  assign w_op_write = (r_state == IDLE) ? w_req_write : r_is_write;
  assign w_op_oor   = (r_state == IDLE) ? w_req_oor   : r_oor;

  assign w_ram_we = ((r_state == RESP) && r_is_write && !r_oor) ? r_be : 2'b00;

  assign mem_resp  = (r_state == RESP);
  assign mem_rdata = r_rdata;

  lc3b_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_idx  (w_ram_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_req) w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == LC3B_MEM_CNT_W'(1)) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture and latency down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= 2'b00;
      r_is_write <= 1'b0;
      r_oor      <= 1'b0;
    end else if ((r_state == IDLE) && w_req) begin
      r_cnt      <= LC3B_MEM_CNT_W'(LATENCY);
      r_idx      <= w_req_idx;
      r_wdata    <= mem_wdata;
      r_be       <= mem_byte_enable;
      r_is_write <= w_req_write;
      r_oor      <= w_req_oor;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - LC3B_MEM_CNT_W'(1);
    end
  end

  // Read data is loaded on the edge entering RESP and held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if ((w_state_nxt == RESP) && !w_op_write) begin
      r_rdata <= w_op_oor ? '0 : w_ram_rdata;
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // dut: LATENCY=2
  logic        rd = 1'b0, wr = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [15:0] addr = '0, wd = '0;
  logic [15:0] rdata;
  logic        resp;
  // dut0: LATENCY=0
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [1:0]  be0 = 2'b00;
  logic [15:0] addr0 = '0, wd0 = '0;
  logic [15:0] rdata0;
  logic        resp0;
`ifdef LC3B_MEM_RANGE_CHECK_EN
  logic        err, err0;
`endif

  int total = 0;
  int bad = 0;
  logic [15:0] t_data;
  int          t_lat;
  bit          t_single;
  bit          t_err;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wd),
    .mem_rdata(rdata), .mem_resp(resp)
`ifdef LC3B_MEM_RANGE_CHECK_EN
    , .mem_err(err)
`endif
  );

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0),
    .mem_byte_enable(be0), .mem_address(addr0), .mem_wdata(wd0),
    .mem_rdata(rdata0), .mem_resp(resp0)
`ifdef LC3B_MEM_RANGE_CHECK_EN
    , .mem_err(err0)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; report first mem_resp cycle after the sampling edge (0 = none)
  task automatic txn(input bit sel, input bit r, input bit w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] b, input bit drop);
    bit done;
    if (sel) begin rd0 = r; wr0 = w; addr0 = a; wd0 = d; be0 = b; end
    else     begin rd  = r; wr  = w; addr  = a; wd  = d; be  = b; end
    t_lat = 0; t_data = 'x; t_err = 1'b0; done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (drop && k == 1) begin rd = 1'b0; wr = 1'b0; addr = 16'h0010; end
      if (sel ? resp0 : resp) begin
        t_lat = k;
        t_data = sel ? rdata0 : rdata;
`ifdef LC3B_MEM_RANGE_CHECK_EN
        t_err = sel ? err0 : err;
`endif
        done = 1'b1;
      end
    end
    if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
    else     begin rd  = 1'b0; wr  = 1'b0; end
    @(negedge clk);
    t_single = !(sel ? resp0 : resp);
  endtask

  task automatic do_wr(input bit sel, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] b, input string tag);
    txn(sel, 1'b0, 1'b1, a, d, b, 1'b0);
    check({tag, "_lat"}, 16'(t_lat), sel ? 16'd1 : 16'd3);
  endtask

  task automatic do_rd(input bit sel, input logic [15:0] a, input logic [15:0] exp,
                       input string tag);
    txn(sel, 1'b1, 1'b0, a, 16'h0000, 2'b00, 1'b0);
    check({tag, "_lat"}, 16'(t_lat), sel ? 16'd1 : 16'd3);
    check({tag, "_data"}, t_data, exp);
    check({tag, "_pulse"}, 16'(t_single), 16'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_resp", 16'(resp), 16'd0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_resp0", 16'(resp0), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read
    do_wr(0, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
    do_rd(0, 16'h0010, 16'hBEEF, "rd_beef");
    do_rd(0, 16'h0011, 16'hBEEF, "rd_odd");

    // Byte-lane writes
    do_wr(0, 16'h0020, 16'h1234, 2'b11, "wr_1234");
    do_wr(0, 16'h0020, 16'hAB00, 2'b10, "wr_hi");
    do_rd(0, 16'h0020, 16'hAB34, "rd_hi");
    do_wr(0, 16'h0020, 16'h00CD, 2'b01, "wr_lo");
    do_rd(0, 16'h0021, 16'hABCD, "rd_lo");
    do_wr(0, 16'h0020, 16'hFFFF, 2'b00, "wr_be00");
    do_rd(0, 16'h0020, 16'hABCD, "rd_be00");

    // Read and write together act as a read
    txn(0, 1'b1, 1'b1, 16'h0010, 16'h0000, 2'b11, 1'b0);
    check("rw_lat", 16'(t_lat), 16'd3);
    check("rw_data", t_data, 16'hBEEF);
    do_rd(0, 16'h0010, 16'hBEEF, "rw_after");

    // Request dropped and address changed during WAIT
    do_wr(0, 16'h0040, 16'h7777, 2'b11, "wr_7777");
    txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b1);
    check("drop_lat", 16'(t_lat), 16'd3);
    check("drop_data", t_data, 16'h7777);
    check("rdata_hold", rdata, 16'h7777);

    // Reset during WAIT of a write
    do_wr(0, 16'h0030, 16'h1111, 2'b11, "wr_1111");
    rd = 1'b0; wr = 1'b1; addr = 16'h0030; wd = 16'h5555; be = 2'b11;
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b0;
    #1 check("rstw_resp_a", 16'(resp), 16'd0);
    @(negedge clk);
    check("rstw_resp_b", 16'(resp), 16'd0);
    check("rstw_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_resp_c", 16'(resp), 16'd0);
    @(negedge clk);
    check("rstw_resp_d", 16'(resp), 16'd0);
    do_rd(0, 16'h0030, 16'h1111, "rd_after_rst");

    // Out-of-range / aliasing
    do_wr(0, 16'h0000, 16'h0A0A, 2'b11, "wr_0a0a");
`ifdef LC3B_MEM_RANGE_CHECK_EN
    txn(0, 1'b0, 1'b1, 16'h0200, 16'h5A5A, 2'b11, 1'b0);
    check("oor_wr_lat", 16'(t_lat), 16'd3);
    check("oor_wr_err", 16'(t_err), 16'd1);
    do_rd(0, 16'h0000, 16'h0A0A, "oor_word0");
    txn(0, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00, 1'b0);
    check("oor_rd_err", 16'(t_err), 16'd1);
    check("oor_rd_data", t_data, 16'h0000);
    do_rd(0, 16'h0010, 16'hBEEF, "inr_rd");
    check("inr_err", 16'(t_err), 16'd0);
`else
    do_wr(0, 16'h0200, 16'h5A5A, 2'b11, "alias_wr");
    do_rd(0, 16'h0000, 16'h5A5A, "alias_rd");
`endif

    // LATENCY=0 instance
    do_wr(1, 16'h0010, 16'h1357, 2'b11, "l0_wr");
    do_rd(1, 16'h0010, 16'h1357, "l0_rd");
    do_wr(1, 16'h0012, 16'h2468, 2'b01, "l0_wr_lo");
    do_wr(1, 16'h0012, 16'h9900, 2'b10, "l0_wr_hi");
    do_rd(1, 16'h0012, 16'h9968, "l0_rd2");
    do_rd(0, 16'h0010, 16'hBEEF, "l2_unaffected");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
